// File: rtl/slug_io_pkg.sv
// slug_board_io shared constants: port word field offsets
// and parameter limits for the board I/O block.
package slug_io_pkg;

  localparam int BTN_LVL_LSB    = 0;
  localparam int BTN_STICKY_LSB = 8;
  localparam int SW_LSB         = 16;
  localparam int LED_DUTY_LSB   = 8;
  localparam int STICKY_CLR_BIT = 31;

  localparam int MAX_LED        = 8;
  localparam int MAX_BTN        = 8;
  localparam int MAX_SW         = 8;
  localparam int MAX_PWM_BITS   = 8;
  localparam int MIN_DEBOUNCE   = 2;

endpackage

// File: rtl/slug_board_io_debounce.sv
// slug_debounce: one-bit two-flop synchronizer followed by
// a consecutive-cycle debouncer.
import slug_io_pkg::*;

module slug_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign o_level   = r_lvl;

  // Synchronize, then flip the level once the input has
  // disagreed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (w_cnt_nxt >= CW'(DEBOUNCE_CYCLES)) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/slug_board_io.sv
// slug_board_io: buttons, switches and LEDs behind a CPU
// port pair. Optional LED PWM under SLUG_IO_PWM_EN.
import slug_io_pkg::*;

module slug_board_io #(
  parameter int N_LED           = 4,
  parameter int N_BTN           = 4,
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int PWM_BITS        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      port_out,
  output logic [31:0]      port_in,
  output logic [N_LED-1:0] led,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_SW-1:0]  sw
);

  logic [N_BTN-1:0] w_lvl;
  logic [N_BTN-1:0] r_lvl_d;
  logic [N_BTN-1:0] r_sticky;
  logic [N_BTN-1:0] w_rise;
  logic [N_SW-1:0]  r_sw1;
  logic [N_SW-1:0]  r_sw2;
  logic             r_clr_d;
  logic             w_clr;
  logic             w_unused;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    slug_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_raw  (btn[g]),
      .o_level(w_lvl[g])
    );
  end

  assign w_rise   = w_lvl & ~r_lvl_d;
  assign w_clr    = port_out[STICKY_CLR_BIT] & ~r_clr_d;
  assign w_unused = ^port_out;

  // Sticky press bits; a new press beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl_d  <= '0;
      r_sticky <= '0;
      r_clr_d  <= 1'b0;
    end else begin
      r_lvl_d  <= w_lvl;
      r_clr_d  <= port_out[STICKY_CLR_BIT];
      r_sticky <= (r_sticky & ~{N_BTN{w_clr}}) | w_rise;
    end
  end

  // Two-flop switch synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
    end
  end

  // Assemble the CPU input word; unused bits read as 0.
  always_comb begin
    port_in = '0;
    port_in[BTN_LVL_LSB +: N_BTN]    = w_lvl;
    port_in[BTN_STICKY_LSB +: N_BTN] = r_sticky;
    port_in[SW_LSB +: N_SW]          = r_sw2;
  end

`ifdef SLUG_IO_PWM_EN
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] w_duty;
  logic                w_on;

  assign w_duty = port_out[LED_DUTY_LSB +: PWM_BITS];
  assign w_on   = (r_pwm < w_duty) || (w_duty == '1);

  // Free-running PWM phase and registered LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
      led   <= '0;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      led   <= port_out[N_LED-1:0] & {N_LED{w_on}};
    end
  end
`else
  // LEDs follow the enable bits, registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= port_out[N_LED-1:0];
    end
  end
`endif

endmodule

// File: doc/slug_board_io.md
SLUG_BOARD_IO -- requirements
Module: slug_board_io

Interface
REQ-001 Parameter N_LED, default 4, number of LED outputs (1..8).
REQ-002 Parameter N_BTN, default 4, number of push-buttons (1..8).
REQ-003 Parameter N_SW, default 4, number of slide switches (1..8).
REQ-004 Parameter DEBOUNCE_CYCLES, default 100000, stable-cycles required to accept a button change (>=2).
REQ-005 Parameter PWM_BITS, default 8, LED brightness resolution (1..8).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 port_out  input  32  CPU output port word.
REQ-009 port_in  output  32  CPU input port word.
REQ-010 led  output  N_LED  board LEDs, active-high.
REQ-011 btn  input  N_BTN  raw asynchronous buttons, active-high.
REQ-012 sw  input  N_SW  raw asynchronous switches.

Function
REQ-013 btn and sw SHALL pass through a two-flop synchronizer; sw reaches port_in exactly 2 cycles after change.
REQ-014 Per button, debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any match resets that button's counter to 0.
REQ-015 Debounce counters SHALL saturate at DEBOUNCE_CYCLES; width = $clog2(DEBOUNCE_CYCLES+1).
REQ-016 A debounced 0->1 transition SHALL set that button's sticky press bit on the next cycle.
REQ-017 A 0->1 transition of port_out[31] (registered edge detect) SHALL clear all sticky bits; level held high clears nothing further.
REQ-018 Set and clear in the same cycle: set SHALL win for that button.
REQ-019 port_in layout: [N_BTN-1:0] debounced levels; [8+N_BTN-1:8] sticky bits; [16+N_SW-1:16] synchronized switches; all other bits 0.
REQ-020 LED enable = port_out[N_LED-1:0]; duty = port_out[8+PWM_BITS-1:8].
REQ-021 Free-running PWM_BITS counter wraps 2^PWM_BITS-1 -> 0.
REQ-022 led[i] SHALL be registered: enable[i] && (cnt < duty || duty == all-ones); duty 0 => always off.
REQ-023 port_out changes SHALL reach led within 1 cycle plus PWM phase; no glitch except at registered edges.

Reset
REQ-024 While rst high: led = 0, port_in = 0, debounced levels, sticky bits, counters, synchronizers, PWM counter and port_out[31] edge register = 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release a held button needs a full DEBOUNCE_CYCLES+2 cycles to appear.

Configuration
REQ-026 Macro SLUG_IO_PWM_EN defined: PWM per REQ-021/022.
REQ-027 SLUG_IO_PWM_EN undefined: no PWM counter; led = registered port_out[N_LED-1:0]; port_out[15:8] ignored; all else identical.

Structure
REQ-028 Package slug_io_pkg SHALL hold port field offsets (BTN_LVL_LSB=0, BTN_STICKY_LSB=8, SW_LSB=16, LED_DUTY_LSB=8, STICKY_CLR_BIT=31) and parameter-limit constants.
REQ-029 Sub-module slug_debounce (one bit, parameter DEBOUNCE_CYCLES, includes synchronizer) SHALL be instantiated N_BTN times via generate.

Verification (bench: DEBOUNCE_CYCLES=4, PWM_BITS=3, N_LED=4)
REQ-030 btn[0] high for 3 cycles then low -> port_in[0] and port_in[8] stay 0.
REQ-031 btn[0] held high -> port_in[0]=1 at cycle 2+4 after edge, port_in[8]=1 one cycle later; stays 1 after release until clear.
REQ-032 port_out[31] 0->1 in same cycle sticky set occurs -> port_in[8] remains 1; next 0->1 with no press -> port_in[8]=0.
REQ-033 port_out=0x0000_0405 (duty 4) -> led=4'b0101 for 4 of every 8 cycles, 0 otherwise; duty 7 -> led=4'b0101 constantly; duty 0 -> led=0.
REQ-034 sw=4'hA -> port_in[19:16]=4'hA exactly 2 cycles later; bits [31:20],[15:12],[7:4]=0.
REQ-035 rst pulsed during btn debounce at count 3 -> all outputs 0 immediately; press visible only after 6 further held cycles.
